// File: rtl/yasac_run_ctrl.sv
// ---------------------------------------------------------------------------
// yasac_run_ctrl
// Runs one test of an attached processor: resets it, lets it settle, pulses
// start, waits for its ready flag (or a timeout), waits a few hold cycles,
// then captures its output ports and compares them against expected values.
//
// Ports
//   CLK        : clock, rising edge
//   RESET      : synchronous active-high reset
//   GO         : run request, level-sampled only in IDLE/DONE
//   DUT_RDY    : processor ready indicator
//   DUT_PORTS  : processor output ports, port k at [k*W +: W]
//   EXP        : expected port values, same packing as DUT_PORTS
//   MASK       : per-port compare enable (1 = compare)
//   DUT_RESET  : reset to processor (RESET or RST state)
//   DUT_START  : one-cycle start pulse to processor
//   BUSY       : run in progress (RST..HOLD)
//   DONE       : run finished, held until the next run starts
//   PASS       : ready seen and every enabled port matched
//   TMO        : run ended by timeout
//   CYCLES     : cycles from DUT_START to ready (saturating)
//   SNAP       : captured DUT_PORTS
// ---------------------------------------------------------------------------
module yasac_run_ctrl #(
    parameter int unsigned W          = 8,
    parameter int unsigned NP         = 8,
    parameter int unsigned RST_CYC    = 1,
    parameter int unsigned SETTLE_CYC = 3,
    parameter int unsigned HOLD_CYC   = 3,
    parameter int unsigned TIMEOUT    = 1000,
    parameter int unsigned CW         = 16
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            GO,
    input  logic            DUT_RDY,
    input  logic [NP*W-1:0] DUT_PORTS,
    input  logic [NP*W-1:0] EXP,
    input  logic [NP-1:0]   MASK,
    output logic            DUT_RESET,
    output logic            DUT_START,
    output logic            BUSY,
    output logic            DONE,
    output logic            PASS,
    output logic            TMO,
    output logic [CW-1:0]   CYCLES,
    output logic [NP*W-1:0] SNAP
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RST    = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_START  = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_HOLD   = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    localparam logic [CW-1:0] CYC_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] CYC_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] TMO_LIM = CW'(TIMEOUT);

    // Saturating increment of the cycle counter.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        if (v == CYC_MAX) begin
            return v;
        end else begin
            return v + CYC_ONE;
        end
    endfunction

    // AND over all ports of (!mask[k] or port k == expected port k).
    function automatic logic ports_match(input logic [NP*W-1:0] ports,
                                         input logic [NP*W-1:0] exp_v,
                                         input logic [NP-1:0]   mask);
        logic ok;
        ok = 1'b1;
        for (int unsigned k = 0; k < NP; k++) begin
            if (mask[k] && (ports[k*W +: W] != exp_v[k*W +: W])) begin
                ok = 1'b0;
            end else begin
                ok = ok;
            end
        end
        return ok;
    endfunction

    logic [2:0]      state_q, state_d;
    logic [31:0]     cnt_q, cnt_d;        // phase length counter (RST/SETTLE/HOLD)
    logic [CW-1:0]   cycles_q, cycles_d;
    logic [NP*W-1:0] snap_q, snap_d;
    logic            pass_q, pass_d;
    logic            tmo_q, tmo_d;
    logic            dut_start_q, dut_start_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    // Next-state and result computation.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cycles_d = cycles_q;
        snap_d   = snap_q;
        pass_d   = pass_q;
        tmo_d    = tmo_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (GO) begin
                    state_d  = S_RST;
                    cnt_d    = 32'd0;
                    cycles_d = {CW{1'b0}};
                    snap_d   = {(NP*W){1'b0}};
                    pass_d   = 1'b0;
                    tmo_d    = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            S_RST: begin
                if (cnt_q + 32'd1 >= RST_CYC) begin
                    cnt_d = 32'd0;
                    if (SETTLE_CYC == 32'd0) begin
                        state_d  = S_START;
                        cycles_d = CYC_ONE;
                    end else begin
                        state_d = S_SETTLE;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_SETTLE: begin
                if (cnt_q + 32'd1 >= SETTLE_CYC) begin
                    cnt_d    = 32'd0;
                    state_d  = S_START;
                    cycles_d = CYC_ONE;    // START cycle is counted as 1
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_START: begin
                // Ready during START is deliberately not looked at.
                state_d  = S_WAIT;
                cycles_d = sat_inc(cycles_q);
            end
            S_WAIT: begin
                // Ready is checked first so it wins over a same-cycle timeout.
                if (DUT_RDY) begin
                    cnt_d = 32'd0;
                    if (HOLD_CYC == 32'd0) begin
                        state_d = S_DONE;
                        snap_d  = DUT_PORTS;
                        pass_d  = ports_match(DUT_PORTS, EXP, MASK);
                    end else begin
                        state_d = S_HOLD;
                    end
                end else if (cycles_q >= TMO_LIM) begin
                    state_d = S_DONE;
                    tmo_d   = 1'b1;
                    pass_d  = 1'b0;
                    snap_d  = DUT_PORTS;
                end else begin
                    cycles_d = sat_inc(cycles_q);
                end
            end
            S_HOLD: begin
                if (cnt_q + 32'd1 >= HOLD_CYC) begin
                    cnt_d   = 32'd0;
                    state_d = S_DONE;
                    snap_d  = DUT_PORTS;
                    pass_d  = ports_match(DUT_PORTS, EXP, MASK);
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 32'd0;
            end
        endcase

        // Status outputs are registered versions of the next-state decode.
        dut_start_d = (state_d == S_START);
        done_d      = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            cnt_q       <= 32'd0;
            cycles_q    <= {CW{1'b0}};
            snap_q      <= {(NP*W){1'b0}};
            pass_q      <= 1'b0;
            tmo_q       <= 1'b0;
            dut_start_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cycles_q    <= cycles_d;
            snap_q      <= snap_d;
            pass_q      <= pass_d;
            tmo_q       <= tmo_d;
            dut_start_q <= dut_start_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Global reset reaches the processor without waiting for a clock edge.
    assign DUT_RESET = RESET | (state_q == S_RST);
    assign DUT_START = dut_start_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign PASS      = pass_q;
    assign TMO       = tmo_q;
    assign CYCLES    = cycles_q;
    assign SNAP      = snap_q;

endmodule

// File: doc/yasac_run_ctrl.md
YASAC_RUN_CTRL -- requirements
Module: yasac_run_ctrl

Interface
Parameters:
REQ-001 The block SHALL have parameter W, default 8: width of each captured port.
REQ-002 The block SHALL have parameter NP, default 8: number of captured DUT output ports.
REQ-003 The block SHALL have parameter RST_CYC, default 1: number of cycles DUT_RESET is held high per run.
REQ-004 The block SHALL have parameter SETTLE_CYC, default 3: idle cycles between DUT_RESET release and DUT_START.
REQ-005 The block SHALL have parameter HOLD_CYC, default 3: cycles waited after RDY before capture.
REQ-006 The block SHALL have parameter TIMEOUT, default 1000: maximum wait cycles for RDY.
REQ-007 The block SHALL have parameter CW, default 16: cycle-counter width.
Ports (name, direction, width, meaning):
REQ-008 The block SHALL have port CLK, input, 1: clock, rising edge.
REQ-009 The block SHALL have port RESET, input, 1: reset; one clock, reset is synchronous and active-high.
REQ-010 The block SHALL have port GO, input, 1: run request, level-sampled in IDLE/DONE.
REQ-011 The block SHALL have port DUT_RDY, input, 1: processor ready indicator.
REQ-012 The block SHALL have port DUT_PORTS, input, NP*W: processor output ports, port k at bits [k*W+W-1:k*W].
REQ-013 The block SHALL have port EXP, input, NP*W: expected port values.
REQ-014 The block SHALL have port MASK, input, NP: per-port compare enable (1 = compare).
REQ-015 The block SHALL have port DUT_RESET, output, 1: reset to processor.
REQ-016 The block SHALL have port DUT_START, output, 1: start pulse to processor.
REQ-017 The block SHALL have port BUSY, output, 1: run in progress.
REQ-018 The block SHALL have port DONE, output, 1: run finished; held high until the next run starts.
REQ-019 The block SHALL have port PASS, output, 1: RDY seen and all masked ports match EXP.
REQ-020 The block SHALL have port TMO, output, 1: run ended by timeout.
REQ-021 The block SHALL have port CYCLES, output, CW: cycles from DUT_START to RDY.
REQ-022 The block SHALL have port SNAP, output, NP*W: captured DUT_PORTS.

Function
REQ-023 The FSM SHALL have states IDLE, RST, SETTLE, START, WAIT, HOLD, DONE, all registered.
REQ-024 In IDLE or DONE with GO=1, the FSM SHALL go to RST next cycle, clearing DONE/PASS/TMO/CYCLES/SNAP; BUSY SHALL be 1 in RST..HOLD.
REQ-025 In RST, DUT_RESET SHALL be 1 for exactly RST_CYC cycles, then the FSM SHALL go to SETTLE.
REQ-026 In SETTLE, the FSM SHALL stay for SETTLE_CYC cycles with DUT_RESET=0 and DUT_START=0, then go to START; SETTLE_CYC=0 SHALL skip SETTLE.
REQ-027 In START, DUT_START SHALL be 1 for exactly one cycle, then the FSM SHALL go to WAIT; CYCLES SHALL count from 1 in that cycle.
REQ-028 In WAIT, CYCLES SHALL increment each cycle, saturating at 2^CW-1.
REQ-029 In WAIT with DUT_RDY=1, the FSM SHALL go to HOLD and freeze CYCLES; DUT_RDY sampled during START SHALL be ignored.
REQ-030 In WAIT, if the wait count reaches TIMEOUT without RDY, the FSM SHALL go to DONE with TMO=1, PASS=0, SNAP=DUT_PORTS at that edge.
REQ-031 If RDY and timeout occur in the same cycle, RDY SHALL win.
REQ-032 HOLD SHALL last HOLD_CYC cycles, then on the exit edge SNAP<=DUT_PORTS, PASS<=AND over k of (!MASK[k] or port k == EXP port k), and the FSM SHALL go to DONE.
REQ-033 MASK=0 SHALL give PASS=1 on any RDY-terminated run.
REQ-034 DONE SHALL assert DONE=1 and hold all results stable while GO=0.
REQ-035 GO SHALL be ignored in RST..HOLD.
REQ-036 DUT_RESET SHALL equal RESET OR (state==RST), so global reset propagates to the processor combinationally.

Reset
REQ-037 RESET=1 at a rising edge SHALL force IDLE, DUT_START=0, BUSY=0, DONE=0, PASS=0, TMO=0, CYCLES=0, SNAP=0, abandoning any run in progress.
REQ-038 The first GO after RESET release SHALL start a complete new sequence.

Verification
REQ-039 Defaults, GO pulse, DUT_RDY high 20 cycles after DUT_START, EXP=DUT_PORTS, MASK=8'hFF -> DUT_RESET 1 cycle, DUT_START after 3 settle cycles, CYCLES=21, DONE after 3 hold cycles, PASS=1, TMO=0.
REQ-040 Same run with port 2 = 8'h5A and EXP port 2 = 8'h5B -> PASS=0; with MASK[2]=0 -> PASS=1.
REQ-041 DUT_RDY never high, TIMEOUT=1000 -> DONE with TMO=1, PASS=0, CYCLES=1000.
REQ-042 RDY first high exactly on the timeout cycle -> TMO=0, HOLD entered.
REQ-043 RESET=1 during WAIT -> next cycle IDLE, all outputs 0, DUT_RESET=1 while RESET high; a new GO runs the full sequence.
REQ-044 GO held high through DONE -> back-to-back runs, flags cleared at each RST entry.
